uart_frame_sched: RTL and testbench

- Frame scheduler and arbiter in front of the shared UART transmitter in the PONG link path.
- Accepts 16-bit update words from up to four game-logic requesters (paddle, ball, score, control) and picks one by round-robin.
- Wraps each word in a 4-byte frame: header, data hi, data lo, XOR checksum.
- Hands the frame to the UART TX byte-by-byte through a start/done handshake, then enforces an inter-frame idle gap so the remote receiver can resynchronise.

---
 rtl/uart_link_pkg.sv | 26 ++
 rtl/uart_frame_sched_rr_arbiter.sv | 48 ++++
 rtl/uart_frame_sched.sv | 161 ++++++++++++++++
 tb/tb_uart_frame_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the PONG UART link. The transmit-side frame
// scheduler and the receive-side frame checker both import this package.
//   state_t      : frame scheduler FSM states
//   FRAME_LEN    : bytes per frame (header, data hi, data lo, checksum)
//   SYNC_DEFAULT : default upper nibble of every header byte
//   frame_chk()  : XOR checksum over the first three frame bytes
package uart_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int FRAME_LEN = 4;

  localparam logic [3:0] SYNC_DEFAULT = 4'hA;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    return hdr ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_frame_sched_rr_arbiter.sv
// Round-robin arbiter with its own last-served register.
//   clk, rst     : clock, synchronous active-high reset
//   req          : level request per requester
//   enable       : when high and some req is set, the winner becomes last
//   last         : index of the most recently served requester
//   grant_onehot : combinational one-hot winner (search from last+1, wrapping)
//   grant_idx    : combinational index of the winner
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [1:0]   last,
  output logic [N-1:0] grant_onehot,
  output logic [1:0]   grant_idx
);

  logic found;

  // Reset points last at the highest index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 2'(N - 1);
    end else if (enable && (|req)) begin
      last <= grant_idx;
    end
  end

  // Priority order is last+1, last+2, ... wrapping at N; the first
  // pending requester in that order wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && (i == ((int'(last) + k) % N)) && req[i]) begin
          found           = 1'b1;
          grant_idx       = 2'(i);
          grant_onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Frame scheduler in front of the shared UART transmitter. Arbitrates
// between requesters round-robin, wraps the winning 16-bit word in a
// 4-byte frame {header, hi, lo, xor}, feeds it to the UART byte by byte
// and then holds an idle gap before the next arbitration.
//   clk, rst : clock, synchronous active-high reset
//   req      : level request per requester
//   payload  : requester i's word at [16i+15:16i]
//   grant    : one-hot pulse, payload of that requester captured
//   done     : one-hot pulse after the frame's last byte completes
//   tx_start : pulse, UART loads tx_data
//   tx_data  : byte being sent, held until the matching tx_done
//   tx_ready : UART idle and able to accept tx_start
//   tx_done  : UART finished the current byte
//   busy     : high in every state except IDLE
module uart_frame_sched
  import uart_link_pkg::*;
#(
  parameter int         N_REQ      = 3,
  parameter int         GAP_CYCLES = 16,
  parameter logic [3:0] SYNC       = SYNC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  payload,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  input  logic                 tx_done,
  output logic                 busy
);

  localparam int              GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [1:0]      LAST_BYTE = 2'(FRAME_LEN - 1);

  state_t              state, state_nxt;
  logic [1:0]          byte_idx, byte_idx_nxt;
  logic [GW-1:0]       gap_cnt, gap_nxt;
  logic [15:0]         hold;
  logic [15:0]         pay_sel;
  logic [7:0]          hdr;
  logic [7:0]          frame_byte;
  logic [N_REQ-1:0]    grant_nxt, done_nxt, served_onehot;
  logic                start_nxt, busy_nxt;
  logic [7:0]          data_nxt;
  logic                arb_en;
  logic [1:0]          last_served;
  logic [N_REQ-1:0]    arb_onehot;
  logic [1:0]          arb_idx;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .enable       (arb_en),
    .last         (last_served),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  // After a grant, last_served is the id of the frame in flight.
  always_comb begin
    pay_sel       = '0;
    served_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_onehot[i]) pay_sel = payload[16*i +: 16];
      served_onehot[i] = (2'(i) == last_served);
    end
  end

  // Frame bytes come from the held copy, so payload edits after grant are invisible.
  always_comb begin
    hdr = {SYNC, 2'b00, last_served};
    case (byte_idx)
      2'd0:    frame_byte = hdr;
      2'd1:    frame_byte = hold[15:8];
      2'd2:    frame_byte = hold[7:0];
      default: frame_byte = frame_chk(hdr, hold[15:8], hold[7:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && (|req)) hold <= pay_sel;
  end

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    gap_nxt      = gap_cnt;
    grant_nxt    = '0;
    done_nxt     = '0;
    start_nxt    = 1'b0;
    data_nxt     = tx_data;
    arb_en       = 1'b0;
    unique case (state)
      IDLE: begin
        arb_en = 1'b1;
        if (|req) begin
          grant_nxt    = arb_onehot;
          byte_idx_nxt = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          start_nxt = 1'b1;
          data_nxt  = frame_byte;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == LAST_BYTE) begin
            done_nxt  = served_onehot;
            gap_nxt   = '0;
            state_nxt = GAP;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      gap_cnt  <= '0;
      grant    <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      gap_cnt  <= gap_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      tx_start <= start_nxt;
      tx_data  <= data_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
module tb_uart_frame_sched;
  localparam int N   = 3;
  localparam int G   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [16*N-1:0]   payload;
  logic [N-1:0]      grant, done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              tx_done;
  logic              busy;

  logic [15:0]       pay_arr [N];
  logic              uart_done = 1'b0, spur_done = 1'b0;
  logic              rand_ready = 1'b0, ready_force = 1'b1;
  bit                rand_lat = 1'b0;
  int                uart_lat = 5;
  int                checks = 0, failures = 0;
  logic [7:0]        byte_q[$];
  int                grant_cnt = 0, done_cnt = 0, proto_err = 0;

  assign payload = {pay_arr[2], pay_arr[1], pay_arr[0]};
  assign tx_done = uart_done | spur_done;

  uart_frame_sched #(.N_REQ(N), .GAP_CYCLES(G), .SYNC(4'hA)) dut (
    .clk(clk), .rst(rst), .req(req), .payload(payload), .grant(grant), .done(done),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: frame contents straight from the byte rules.
  function automatic logic [31:0] model_frame(input int id, input logic [15:0] p);
    logic [7:0] h;
    h = 8'hA0 | 8'(id);
    return {h, p[15:8], p[7:0], h ^ p[15:8] ^ p[7:0]};
  endfunction

  // Reference: first pending requester after last, wrapping.
  function automatic int model_rr(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (|grant) begin
        id = onehot_idx(grant);
        break;
      end
    end
    if (id < 0) timeout("wait_grant");
  endtask

  task automatic wait_done(output int id);
    id = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (|done) begin
        id = onehot_idx(done);
        break;
      end
    end
    if (id < 0) timeout("wait_done");
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 400) begin
      tick();
      c++;
    end
    if (busy) timeout("wait_idle");
  endtask

  task automatic pop_frame(output logic [31:0] f);
    f = '0;
    if (byte_q.size() < 4) begin
      timeout("frame_bytes");
    end else begin
      for (int i = 0; i < 4; i++) f = {f[23:0], byte_q.pop_front()};
    end
  endtask

  // tx_ready driver: forced level or random backpressure.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // UART model: tx_done a fixed or random number of cycles after each tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        int l;
        l = rand_lat ? int'($urandom_range(1, 8)) : uart_lat;
        repeat (l) @(posedge clk);
        #1 uart_done = 1'b1;
        @(posedge clk);
        #1 uart_done = 1'b0;
      end
    end
  end

  // Monitor: logs bytes, counts pulses, flags handshake violations.
  initial begin
    logic       outstanding;
    logic [7:0] held;
    outstanding = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 1'b0;
      end else begin
        if (tx_start) begin
          if (outstanding) proto_err++;
          byte_q.push_back(tx_data);
          held = tx_data;
          outstanding = 1'b1;
        end else if (outstanding && tx_data !== held) begin
          proto_err++;
        end
        if (tx_done && outstanding && !tx_start) outstanding = 1'b0;
      end
      if (|grant) grant_cnt++;
      if (|done) done_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          id;
    logic [15:0] pay;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    int          g, d, cnt, lo, last, dc;
    logic [31:0] f;
    logic [7:0]  d0;
    logic        stable;
    logic [N-1:0] mask;
    logic [15:0] cur [N];

    tbl[0] = '{0, 16'h1234, 32'hA0123486};
    tbl[1] = '{1, 16'h0002, 32'hA10002A3};
    tbl[2] = '{2, 16'hBEEF, 32'hA2BEEFF3};
    tbl[3] = '{1, 16'hFFFF, 32'hA1FFFFA1};
    tbl[4] = '{2, 16'h0000, 32'hA20000A2};
    tbl[5] = '{0, 16'h5A5A, 32'hA05A5AA0};

    for (int i = 0; i < N; i++) pay_arr[i] = '0;
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // tx_done in IDLE is ignored
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    check("spur_idle_busy", 32'(busy), 0);
    check("spur_idle_start", 32'(tx_start), 0);

    // Single request with payload change after grant and spurious tx_done in GAP
    pay_arr[0] = 16'h1234;
    req = 3'b001;
    wait_grant(g);
    check("single_grant_id", g, 0);
    check("single_grant_vec", 32'(grant), 32'h1);
    check("single_busy", 32'(busy), 1);
    req = '0;
    pay_arr[0] = 16'hFFFF;
    tick();
    check("single_first_start", 32'(tx_start), 1);
    wait_done(d);
    check("single_done_id", d, 0);
    pop_frame(f);
    check("single_frame", f, 32'hA0123486);
    cnt = 0;
    while (busy && cnt < 100) begin
      spur_done = (cnt == 3);
      tick();
      cnt++;
    end
    spur_done = 1'b0;
    check("single_gap_len", cnt, G);
    check("single_grant_cnt", grant_cnt, 1);
    check("single_done_cnt", done_cnt, 1);

    // Table: one requester at a time, payload flipped right after grant
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      uart_lat = 1 + i;
      pay_arr[2'(tbl[i].id)] = tbl[i].pay;
      req = 3'(1 << tbl[i].id);
      wait_grant(g);
      check("tbl_grant", g, tbl[i].id);
      req = '0;
      pay_arr[2'(tbl[i].id)] = ~tbl[i].pay;
      wait_done(d);
      check("tbl_done", d, tbl[i].id);
      pop_frame(f);
      check("tbl_frame", f, tbl[i].exp);
    end
    uart_lat = 5;

    // All three requesting: fair rotation, one IDLE cycle between frames
    wait_idle();
    do_reset();
    pay_arr[0] = 16'h0001;
    pay_arr[1] = 16'h0002;
    pay_arr[2] = 16'h0003;
    req = 3'b111;
    last = N - 1;
    wait_grant(g);
    for (int k = 0; k < 6; k++) begin
      check("rr_order", g, model_rr(3'b111, last));
      last = g;
      if (k == 5) req = '0;
      wait_done(d);
      check("rr_done", d, g);
      pop_frame(f);
      check("rr_frame", f, model_frame(g, pay_arr[2'(g)]));
      if (k < 5) begin
        lo = 0;
        for (int c = 0; c < 200; c++) begin
          tick();
          if (!busy) lo++;
          else if (lo > 0) break;
        end
        check("rr_idle_cycles", lo, 1);
        g = onehot_idx(grant);
      end
    end

    // Backpressure: no start while tx_ready low
    wait_idle();
    do_reset();
    ready_force = 1'b0;
    pay_arr[0] = 16'h1234;
    req = 3'b001;
    wait_grant(g);
    req = '0;
    d0 = tx_data;
    cnt = 0;
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (tx_start) cnt++;
      if (tx_data !== d0) stable = 1'b0;
    end
    check("bp_no_start", cnt, 0);
    check("bp_data_stable", 32'(stable), 1);
    ready_force = 1'b1;
    tick();
    check("bp_start_after_ready", 32'(tx_start), 1);
    wait_done(d);
    pop_frame(f);
    check("bp_frame", f, 32'hA0123486);

    // Reset during WAIT of byte 2
    wait_idle();
    pay_arr[1] = 16'hBEEF;
    req = 3'b010;
    wait_grant(g);
    check("mid_grant", g, 1);
    cnt = 0;
    while (byte_q.size() < 3 && cnt < 400) begin
      tick();
      cnt++;
    end
    if (byte_q.size() < 3) timeout("mid_bytes");
    dc = done_cnt;
    rst = 1'b1;
    tick();
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_start", 32'(tx_start), 0);
    check("mid_rst_data", 32'(tx_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    req = '0;
    repeat (12) tick();
    check("mid_no_done", done_cnt, dc);
    byte_q.delete();
    pay_arr[0] = 16'h1234;
    req = 3'b011;
    wait_grant(g);
    check("mid_first_winner", g, 0);
    req = 3'b010;
    wait_done(d);
    pop_frame(f);
    check("mid_frame0", f, model_frame(0, 16'h1234));
    wait_grant(g);
    check("mid_second_winner", g, 1);
    req = '0;
    wait_done(d);
    pop_frame(f);
    check("mid_frame1", f, model_frame(1, 16'hBEEF));

    // Randomized traffic against the reference model
    wait_idle();
    do_reset();
    rand_ready = 1'b1;
    rand_lat = 1'b1;
    last = N - 1;
    mask = 3'($urandom_range(1, 7));
    for (int i = 0; i < N; i++) pay_arr[i] = 16'($urandom);
    req = mask;
    wait_grant(g);
    for (int k = 0; k < 20; k++) begin
      check("rnd_winner", g, model_rr(mask, last));
      for (int i = 0; i < N; i++) cur[i] = pay_arr[i];
      last = model_rr(mask, last);
      mask = (k == 19) ? 3'b000 : 3'($urandom_range(1, 7));
      for (int i = 0; i < N; i++) pay_arr[i] = 16'($urandom);
      req = mask;
      wait_done(d);
      check("rnd_done", d, last);
      pop_frame(f);
      check("rnd_frame", f, model_frame(last, cur[2'(last)]));
      if (k < 19) wait_grant(g);
    end
    rand_ready = 1'b0;
    wait_idle();
    repeat (20) tick();

    check("protocol_violations", proto_err, 0);
    check("leftover_bytes", byte_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
